// File: rtl/mc_run_sched.sv
// mc_run_sched: Monte Carlo run scheduler feeding a bank of sim_mng lanes with seeds.
// Optional per-lane watchdog is built when MC_WATCHDOG_EN is defined.

module mc_run_lane
`ifdef MC_WATCHDOG_EN
#(
    parameter int WDOG_CYCLES = 4096
)
`endif
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_launch,
    input  logic [22:0] i_seed,
    input  logic        i_done,
    input  logic        i_y,
    output logic        o_idle,
    output logic        o_start,
    output logic [22:0] o_seed,
    output logic        o_retire,
    output logic        o_hit
`ifdef MC_WATCHDOG_EN
    ,output logic       o_tmo
`endif
);
    typedef enum logic [1:0] {LIDLE, LAUNCH, ARM, RUN} lane_state_t;

    lane_state_t r_state, w_state_nxt;
    logic        r_start;
    logic [22:0] r_seed;
    logic        w_expired;

`ifdef MC_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0] r_wdog;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_wdog <= '0;
        else if (r_state == LAUNCH)
            r_wdog <= '0;
        else if ((r_state == ARM || r_state == RUN) && r_wdog != WD_W'(WDOG_CYCLES))
            r_wdog <= r_wdog + 1'b1;
    end

    // a done arriving on the expiry cycle still counts as a real result
    assign w_expired = (r_state == RUN) && !i_done && (r_wdog == WD_W'(WDOG_CYCLES));
    assign o_tmo     = w_expired;
`else
    assign w_expired = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= LIDLE;
        else          r_state <= w_state_nxt;
    end

    // LAUNCH is a blanking cycle: sim_mng still shows the previous done
    always_comb begin
        w_state_nxt = r_state;
        o_retire    = 1'b0;
        o_hit       = 1'b0;
        unique case (r_state)
            LIDLE:  if (i_launch) w_state_nxt = LAUNCH;
            LAUNCH: w_state_nxt = ARM;
            ARM:    w_state_nxt = RUN;
            RUN: begin
                if (i_done) begin
                    w_state_nxt = LIDLE;
                    o_retire    = 1'b1;
                    o_hit       = i_y;
                end else if (w_expired) begin
                    w_state_nxt = LIDLE;
                    o_retire    = 1'b1;
                end
            end
            default: w_state_nxt = LIDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_start <= 1'b0;
            r_seed  <= '0;
        end else begin
            r_start <= (r_state == LIDLE) && i_launch;
            if (r_state == LIDLE && i_launch) r_seed <= i_seed;
        end
    end

    assign o_idle  = (r_state == LIDLE);
    assign o_start = r_start;
    assign o_seed  = r_seed;
endmodule

module mc_run_sched #(
    parameter int          NUM_LANES   = 4,
    parameter int          CNT_W       = 16,
    parameter logic [22:0] SEED_STRIDE = 23'd40503,
    parameter int          WDOG_CYCLES = 4096
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic [CNT_W-1:0]         i_n_runs,
    input  logic [22:0]              i_base_seed,
    output logic [NUM_LANES-1:0]     o_lane_start,
    output logic [23*NUM_LANES-1:0]  o_lane_seed,
    input  logic [NUM_LANES-1:0]     i_lane_done,
    input  logic [NUM_LANES-1:0]     i_lane_y,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [CNT_W-1:0]         o_runs_done,
    output logic [CNT_W-1:0]         o_hits,
    output logic [CNT_W-1:0]         o_timeouts
);
    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, FINISH} state_t;

    state_t                        r_state, w_state_nxt;
    logic [CNT_W-1:0]              r_n_runs, r_launched, r_runs_done, r_hits;
    logic [22:0]                   r_seed_acc;
    logic                          r_busy, r_done;
    logic [NUM_LANES-1:0]          w_idle, w_grant, w_retire, w_hit;
    logic [NUM_LANES-1:0][22:0]    w_seed;
    logic [22:0]                   w_seed_out;
    logic                          w_accept, w_dispatch;

    function automatic logic [4:0] popcnt(input logic [NUM_LANES-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < NUM_LANES; i++) n = n + 5'(v[i]);
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [4:0] b);
        logic [CNT_W+4:0] s;
        s = {5'd0, a} + {{CNT_W{1'b0}}, b};
        return (s > {5'd0, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    assign w_accept   = i_start && (r_state == IDLE || r_state == FINISH);
    assign w_dispatch = (r_state == DISPATCH) && (r_launched != r_n_runs);
    // an all-zero LFSR seed never leaves zero
    assign w_seed_out = (r_seed_acc == '0) ? 23'd1 : r_seed_acc;

    always_comb begin
        w_grant = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (w_dispatch && w_idle[i]) begin
                w_grant    = '0;
                w_grant[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE, FINISH: if (i_start) w_state_nxt = (i_n_runs == '0) ? FINISH : DISPATCH;
            DISPATCH:     if (r_launched == r_n_runs) w_state_nxt = DRAIN;
            DRAIN:        if (&w_idle) w_state_nxt = FINISH;
            default:      w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_n_runs    <= '0;
            r_launched  <= '0;
            r_seed_acc  <= '0;
            r_runs_done <= '0;
            r_hits      <= '0;
        end else begin
            r_busy <= (w_state_nxt == DISPATCH) || (w_state_nxt == DRAIN);
            r_done <= (w_state_nxt == FINISH);
            if (w_accept) begin
                r_n_runs    <= i_n_runs;
                r_seed_acc  <= i_base_seed;
                r_launched  <= '0;
                r_runs_done <= '0;
                r_hits      <= '0;
            end else begin
                if (|w_grant) begin
                    r_launched <= r_launched + 1'b1;
                    r_seed_acc <= r_seed_acc + SEED_STRIDE;
                end
                r_runs_done <= sat_add(r_runs_done, popcnt(w_retire));
                r_hits      <= sat_add(r_hits, popcnt(w_hit));
            end
        end
    end

`ifdef MC_WATCHDOG_EN
    logic [NUM_LANES-1:0] w_tmo;
    logic [CNT_W-1:0]     r_timeouts;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)      r_timeouts <= '0;
        else if (w_accept) r_timeouts <= '0;
        else               r_timeouts <= sat_add(r_timeouts, popcnt(w_tmo));
    end
    assign o_timeouts = r_timeouts;
`else
    assign o_timeouts = '0;
`endif

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        mc_run_lane
`ifdef MC_WATCHDOG_EN
        #(.WDOG_CYCLES(WDOG_CYCLES))
`endif
        u_lane (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_launch (w_grant[g]),
            .i_seed   (w_seed_out),
            .i_done   (i_lane_done[g]),
            .i_y      (i_lane_y[g]),
            .o_idle   (w_idle[g]),
            .o_start  (o_lane_start[g]),
            .o_seed   (w_seed[g]),
            .o_retire (w_retire[g]),
            .o_hit    (w_hit[g])
`ifdef MC_WATCHDOG_EN
            ,.o_tmo   (w_tmo[g])
`endif
        );
    end

    assign o_lane_seed = w_seed;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_runs_done = r_runs_done;
    assign o_hits      = r_hits;
endmodule

// File: doc/mc_run_sched.md
# mc_run_sched

Monte Carlo run scheduler that drives a bank of `sim_mng` lanes. It launches `n_runs` independent Hawkes simulations across `NUM_LANES` instances and hands each launch a distinct nonzero LFSR seed. It accumulates the depletion outcomes (`y`) into a hit count, so upstream logic can form the estimate hits/runs. It sits between the host/config registers and the `sim_mng` array.

## Interface
- `NUM_LANES`, default 4: number of `sim_mng` instances driven (1..16).
- `CNT_W`, default 16: width of the run and hit counters.
- `SEED_STRIDE`, default 23'd40503: odd increment applied between consecutive seeds.
- `WDOG_CYCLES`, default 4096: per-lane timeout. Used only with `MC_WATCHDOG_EN`.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle request to begin a batch. Sampled only in IDLE or FINISH.
- `n_runs`  in  CNT_W  runs in the batch. Latched on an accepted `start`.
- `base_seed`  in  23  seed for run 0. Latched on an accepted `start`.
- `lane_start`  out  NUM_LANES  per-lane one-cycle start pulse to `sim_mng.start`.
- `lane_seed`  out  23*NUM_LANES  per-lane seed. Lane i occupies bits [23i+22:23i]. Held stable from the launch until the next launch of that lane.
- `lane_done`  in  NUM_LANES  `sim_mng.done` per lane (level, cleared by that lane's start).
- `lane_y`  in  NUM_LANES  `sim_mng.y` per lane. Valid while `lane_done` is high.
- `busy`  out  1  a batch is in progress.
- `done`  out  1  batch complete. Level, held until the next accepted `start`.
- `runs_done`  out  CNT_W  runs retired in the current or last batch.
- `hits`  out  CNT_W  retired runs with y=1.
- `timeouts`  out  CNT_W  runs aborted by the watchdog. Constant 0 without the macro.

## Operation
- Top FSM states:
  - IDLE: waits for `start`. n_runs=0 goes to FINISH; otherwise goes to DISPATCH.
  - DISPATCH: launches runs until `launched == n_runs`, then goes to DRAIN.
  - DRAIN: waits until every lane is LIDLE, then goes to FINISH.
  - FINISH: `done` is high. A new `start` returns to DISPATCH (or to FINISH again if n_runs=0) and clears all counters.
- Lane FSMs, one per lane:
  - LIDLE → LAUNCH: `lane_start[i]` is high for exactly one cycle and `lane_seed[i]` is loaded.
  - LAUNCH → ARM: one blanking cycle. `lane_done` is ignored, because `sim_mng` clears `done` only on the edge that samples start.
  - ARM → RUN.
  - RUN → LIDLE: on `lane_done[i]==1`. The run retires.
- Dispatch rules:
  - At most one launch per cycle.
  - The lowest-index lane in LIDLE wins (fixed priority).
  - A lane that retires in cycle c can be relaunched no earlier than cycle c+1.
- Seed generation:
  - The seed accumulator starts at `base_seed` and adds `SEED_STRIDE` mod 2^23 after each launch.
  - A computed value of 0 is sent as 23'h000001, because an LFSR seed of 0 locks up. The accumulator itself keeps the unmodified value.
- Retirement:
  - Multiple lanes may retire in the same cycle.
  - `runs_done` increases by popcount(retiring).
  - `hits` increases by popcount(retiring & lane_y).
  - Both updates happen in one cycle.
- Counters saturate at 2^CNT_W−1 and never wrap.
- `start` while `busy` is ignored, with no effect on any state.

## Timing
- Reset values: all lane FSMs LIDLE, top FSM IDLE. `lane_start`=0, `lane_seed`=0, `busy`=0, `done`=0, `runs_done`=0, `hits`=0, `timeouts`=0.
- Reset is asynchronous. Asserting `rst_n` mid-batch abandons in-flight runs. `lane_start` falls immediately and the next batch needs a fresh `start`.
- `start` sampled at edge 0 gives `busy`=1 and `done`=0 after edge 0. The first `lane_start[0]` is high in cycle 1.
- Minimum per-run overhead is 3 cycles (LAUNCH, ARM, retire) plus the `sim_mng` runtime.
- `done` rises one cycle after the cycle in which the last lane returns to LIDLE. `busy` falls in the same cycle.
- n_runs=0: `done`=1 and `busy`=0 one cycle after `start`, with all counters 0.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `MC_WATCHDOG_EN` defined:
  - Each lane has a cycle counter that clears on LAUNCH and increments in ARM and RUN.
  - If it reaches `WDOG_CYCLES` before `lane_done`, the lane retires as a timeout.
  - A timeout increments `runs_done` and `timeouts`, and leaves `hits` unchanged.
  - If `lane_done` and expiry coincide, `lane_done` wins.
- Undefined: no watchdog logic is built, `timeouts` is tied to 0, and a hung lane stalls DRAIN indefinitely.

## Test plan
- Reset: `rst_n`=0 mid-batch with 3 lanes running → all outputs at reset values on the same cycle; `lane_start`=0 afterwards.
- Single lane, `NUM_LANES`=1, n_runs=3, base_seed=12, behavioural lane model with done after 10 cycles and y=1,0,1:
  - seeds 12, 40515, 81018;
  - `hits`=2 and `runs_done`=3;
  - `done` high in cycle 1+3·13 relative to `start`.
- Four lanes, n_runs=8, all lanes finish in the same cycle with y=1111 → `runs_done` steps 0→4 in one cycle; final `hits`=8; launches go in lane order 0,1,2,3.
- Zero-seed substitution: base_seed=0 → `lane_seed[0]`=1 and the next seed is 40503.
- Edge cases:
  - n_runs=0 → `done` one cycle after `start`, no `lane_start` pulses.
  - `start` pulsed while busy → ignored and `n_runs` not relatched.
- With `MC_WATCHDOG_EN`, `WDOG_CYCLES`=64, lane 1 never asserts done, n_runs=4 → `timeouts`=1, `runs_done`=4, `done` asserted.
